// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the Clause-22 MDIO management master.
// Holds the sequencer state encoding and the fixed header field codes.
package mdio_pkg;

    typedef enum logic [2:0] {
        StRstHold,
        StRstWait,
        StIdle,
        StFrame,
        StDone
    } state_e;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int unsigned FRAME_CORE_BITS = 32;

    // First 16 bits after the preamble: ST, OP, PHYAD, REGAD, TA.
    // A read puts 11 in the TA slot; the pins are released there anyway.
    function automatic logic [15:0] frame_header(input logic       is_write,
                                                 input logic [4:0] phy,
                                                 input logic [4:0] regad);
        return {ST_CODE, (is_write ? OP_WRITE : OP_READ), phy, regad,
                (is_write ? TA_WRITE : 2'b11)};
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: one bit period is 2*CLK_DIV cycles, low half first.
// Strobes flag the cycle just before the corresponding MDC edge.
module mdio_clk_gen #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic mdc_o,
    output logic fall_stb_o,
    output logic rise_stb_o
);

    localparam int unsigned PeriodCycles = 2 * CLK_DIV;
    localparam int unsigned CntW         = $clog2(PeriodCycles);
    localparam logic [CntW-1:0] CntLast  = CntW'(PeriodCycles - 1);
    localparam logic [CntW-1:0] CntHigh  = CntW'(CLK_DIV);
    localparam logic [CntW-1:0] CntPreHi = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mdc_q, mdc_d;

    // Parking the counter at its last value makes the first enabled cycle phase 0.
    always_comb begin
        cnt_d = CntLast;
        mdc_d = 1'b0;
        if (en_i) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
            mdc_d = (cnt_d >= CntHigh);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= CntLast;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    assign mdc_o      = mdc_q;
    assign fall_stb_o = mdc_q && (cnt_q == CntLast);
    assign rise_stb_o = !mdc_q && (cnt_q == CntPreHi);

endmodule

// File: rtl/mdio_phy_manager.sv
// Clause-22 MDIO master with PHY hardware-reset sequencing and a start/done handshake.
// Sequencer, reset counters, bit counter and the 16-bit data shift register live here.
module mdio_phy_manager
    import mdio_pkg::*;
#(
    parameter int unsigned CLK_DIV           = 25,
    parameter int unsigned PREAMBLE_BITS     = 32,
    parameter int unsigned RESET_CYCLES      = 1250000,
    parameter int unsigned POST_RESET_CYCLES = 625000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    input  logic        write_en,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wr_data,
    output logic        done_port,
    output logic [15:0] return_port,
    output logic        error,
    output logic        busy,
    output logic        ready,
    output logic        eth_mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
    output logic        eth_reset_n
);

    localparam int unsigned TotalBits = PREAMBLE_BITS + FRAME_CORE_BITS;
    localparam int unsigned BitW      = $clog2(TotalBits);
    localparam logic [BitW-1:0] LastBit  = BitW'(TotalBits - 1);
    localparam logic [BitW-1:0] OeOffBit = BitW'(PREAMBLE_BITS + 14);
    localparam logic [BitW-1:0] TaBit    = BitW'(PREAMBLE_BITS + 15);
    localparam logic [BitW-1:0] DataBit  = BitW'(PREAMBLE_BITS + 16);

    localparam int unsigned RstCntMax =
        (RESET_CYCLES > POST_RESET_CYCLES) ? RESET_CYCLES : POST_RESET_CYCLES;
    localparam int unsigned RstCntW = $clog2(RstCntMax + 1);
    localparam logic [RstCntW-1:0] RstHoldLast = RstCntW'(RESET_CYCLES - 1);
    localparam logic [RstCntW-1:0] RstWaitLast = RstCntW'(POST_RESET_CYCLES - 1);

    state_e              state_q;
    logic [RstCntW-1:0]  rst_cnt_q;
    logic [BitW-1:0]     bit_q;
    logic [15:0]         hdr_q;
    logic [15:0]         shreg_q;
    logic                write_q;
    logic                ta_err_q;
    logic                done_q;
    logic [15:0]         ret_q;
    logic                err_q;
    logic                busy_q;
    logic                ready_q;
    logic                rstn_q;
    logic                mdio_o_q;
    logic                mdio_oe_q;

    logic                fall_stb;
    logic                rise_stb;
    logic                clk_en;
    logic                accept;
    logic                last_fall;
    logic [15:0]         hdr_new;
    logic [BitW-1:0]     bit_nxt;
    logic                tx_nxt;

    // Serial value of frame bit idx: preamble ones, then header, then data.
    function automatic logic tx_bit(input logic [BitW-1:0] idx,
                                    input logic [15:0]     hdr,
                                    input logic            data_bit);
        int unsigned pos;
        pos = 32'(idx);
        if (pos < PREAMBLE_BITS) begin
            return 1'b1;
        end
        if (pos < PREAMBLE_BITS + 16) begin
            return hdr[4'(PREAMBLE_BITS + 15 - pos)];
        end
        return data_bit;
    endfunction

    assign hdr_new   = frame_header(write_en, phy_addr, reg_addr);
    assign bit_nxt   = bit_q + 1'b1;
    assign accept    = (state_q == StIdle) && start_port;
    assign last_fall = (state_q == StFrame) && fall_stb && (bit_q == LastBit);
    // The generator runs one cycle ahead of FRAME so bit 0 starts right after accept.
    assign clk_en    = accept || ((state_q == StFrame) && !last_fall);

    // Entering data bit 0 uses the MSB; later data bits see it after the pending shift.
    always_comb begin
        tx_nxt = tx_bit(bit_nxt, hdr_q, (bit_nxt == DataBit) ? shreg_q[15] : shreg_q[14]);
    end

    mdio_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk_i     (clock),
        .rst_i     (reset),
        .en_i      (clk_en),
        .mdc_o     (eth_mdc),
        .fall_stb_o(fall_stb),
        .rise_stb_o(rise_stb)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StRstHold;
            rst_cnt_q <= '0;
            bit_q     <= '0;
            hdr_q     <= '0;
            shreg_q   <= '0;
            write_q   <= 1'b0;
            ta_err_q  <= 1'b0;
            done_q    <= 1'b0;
            ret_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            rstn_q    <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StRstHold: begin
                    if (rst_cnt_q == RstHoldLast) begin
                        rst_cnt_q <= '0;
                        rstn_q    <= 1'b1;
                        state_q   <= StRstWait;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                StRstWait: begin
                    if (rst_cnt_q == RstWaitLast) begin
                        rst_cnt_q <= '0;
                        ready_q   <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                StIdle: begin
                    if (start_port) begin
                        hdr_q     <= hdr_new;
                        shreg_q   <= wr_data;
                        write_q   <= write_en;
                        ta_err_q  <= 1'b0;
                        bit_q     <= '0;
                        busy_q    <= 1'b1;
                        mdio_o_q  <= tx_bit('0, hdr_new, wr_data[15]);
                        mdio_oe_q <= 1'b1;
                        state_q   <= StFrame;
                    end
                end
                StFrame: begin
                    if (rise_stb && !write_q) begin
                        if (bit_q == TaBit) begin
                            ta_err_q <= mdio_i;
                        end
                        if (bit_q >= DataBit) begin
                            shreg_q <= {shreg_q[14:0], mdio_i};
                        end
                    end
                    if (fall_stb) begin
                        if (bit_q == LastBit) begin
                            done_q    <= 1'b1;
                            err_q     <= write_q ? 1'b0 : ta_err_q;
                            if (!write_q) begin
                                ret_q <= shreg_q;
                            end
                            mdio_o_q  <= 1'b1;
                            mdio_oe_q <= 1'b0;
                            state_q   <= StDone;
                        end else begin
                            bit_q     <= bit_nxt;
                            mdio_o_q  <= tx_nxt;
                            mdio_oe_q <= write_q || (bit_nxt < OeOffBit);
                            if (write_q && (bit_nxt > DataBit)) begin
                                shreg_q <= {shreg_q[14:0], 1'b0};
                            end
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StRstHold;
            endcase
        end
    end

    assign done_port   = done_q;
    assign return_port = ret_q;
    assign error       = err_q;
    assign busy        = busy_q;
    assign ready       = ready_q;
    assign mdio_o      = mdio_o_q;
    assign mdio_oe     = mdio_oe_q;
    assign eth_reset_n = rstn_q;

endmodule

// File: doc/mdio_phy_manager.md
# mdio_phy_manager

Parametrised Clause-22 MDIO management master with built-in PHY reset sequencing, sitting between the HLS controller's start/done handshake and the SGMII PHY's management pins (eth_mdc, eth_mdio, eth_reset_n). It replaces the fixed PHY reset and management wiring in the Ethernet top level. It adds a programmable MDC rate, a configurable preamble, single-register read/write transactions and turnaround error detection.

## Interface
Parameters:
- CLK_DIV, 25: MDC half-period in clock cycles, ≥2 (125 MHz / 50 = 2.5 MHz MDC).
- PREAMBLE_BITS, 32: number of preamble ones, 0..32.
- RESET_CYCLES, 1250000: clock cycles eth_reset_n is held low after reset release, ≥1.
- POST_RESET_CYCLES, 625000: cycles after eth_reset_n rises before ready asserts, ≥1.

Ports (all synchronous to clock; one clock; reset is synchronous and active-high):
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start_port  in  1  transaction request; accepted only while ready=1 and busy=0.
- write_en  in  1  1 = write, 0 = read; sampled with start_port.
- phy_addr  in  5  PHY address; sampled with start_port.
- reg_addr  in  5  register address; sampled with start_port.
- wr_data  in  16  write data; sampled with start_port.
- done_port  out  1  one-cycle completion pulse.
- return_port  out  16  read data; valid from done_port, held until the next done.
- error  out  1  read turnaround fault; valid with done_port, held until the next done.
- busy  out  1  transaction in progress.
- ready  out  1  PHY reset sequence complete.
- eth_mdc  out  1  management clock.
- mdio_o  out  1  MDIO output data (the top level builds the IOBUF).
- mdio_oe  out  1  MDIO output enable.
- mdio_i  in  1  MDIO input; the board pull-up reads it as 1 when undriven.
- eth_reset_n  out  1  PHY hardware reset, active low.

## Operation
- States: RST_HOLD → RST_WAIT → IDLE → FRAME → DONE → IDLE.
- RST_HOLD: eth_reset_n=0 for RESET_CYCLES cycles, then goes to RST_WAIT.
- RST_WAIT: eth_reset_n=1 for POST_RESET_CYCLES cycles, then goes to IDLE. ready=1 from entry to IDLE onward.
- IDLE: eth_mdc=0, mdio_oe=0.
  - start_port=1 latches the request fields, sets busy=1 and enters FRAME.
  - start_port while ready=0 or busy=1 is ignored, with no done pulse.
- FRAME: the shift sequence is PREAMBLE_BITS ones, then ST=01, then OP (write 01, read 10), then PHYAD[4:0] MSB first, then REGAD[4:0] MSB first, then TA, then DATA[15:0] MSB first.
  - Write: TA=10 driven; mdio_oe=1 for the whole frame.
  - Read: mdio_oe=0 from the first TA bit through the end of the frame.
  - Read turnaround check: the second TA bit samples mdio_i. If it is 1, error=1.
  - Read data: DATA bits are shifted into return_port. On an error, return_port still takes the sampled bits (0xFFFF with the pull-up).
- DONE: one cycle with done_port=1; return_port and error update; busy=0 in the following cycle.
- Write transactions leave return_port unchanged and set error=0.

## Timing
- Reset values:
  - eth_reset_n=0, eth_mdc=0, mdio_o=1, mdio_oe=0.
  - done_port=0, return_port=0, error=0, busy=0, ready=0.
  - State RST_HOLD.
- Reset mid-transaction: the frame aborts with no done pulse, and the PHY reset sequence restarts from RST_HOLD.
- Bit timing: each bit lasts 2·CLK_DIV cycles, with eth_mdc low for the first CLK_DIV cycles and high for the last CLK_DIV.
- Output changes: mdio_o and mdio_oe change only in the cycle eth_mdc goes low.
- Input sampling: mdio_i is sampled in the cycle eth_mdc goes high.
- Accept/done latency: a start accepted at cycle T gives bit 0 starting at T+1, and done_port at T+1+(PREAMBLE_BITS+32)·2·CLK_DIV.
- Back-to-back: a start in the cycle after done_port is accepted; the minimum gap between frames is 2 cycles.
- eth_mdc stays low outside FRAME. It never produces a high phase shorter than CLK_DIV cycles.

## Structure
- Package mdio_pkg:
  - state enum;
  - ST_CODE=2'b01, OP_WRITE=2'b01, OP_READ=2'b10, TA_WRITE=2'b10;
  - FRAME_CORE_BITS=32.
- Sub-module mdio_clk_gen (CLK_DIV): generates eth_mdc and the one-cycle fall_stb/rise_stb strobes. It is enabled by FRAME; disabling it forces mdc low and resets its counter.
- The top module holds the sequencer FSM, the reset counters, the bit counter and a 16-bit shift register.

## Test plan
- Reset sequence: bench with RESET_CYCLES=100, POST_RESET_CYCLES=50 → eth_reset_n low for 100 cycles after reset drops, high at cycle 101, ready=1 at cycle 151.
- Write frame: CLK_DIV=4, PREAMBLE_BITS=32, write phy=0x01, reg=0x00, data=0x1140 → MDC-sampled bitstream is 32×1, 0101, 00001, 00000, 10, 0x1140. done_port arrives 513 cycles after accept; mdio_oe=1 throughout.
- Read frame: read phy=0x01, reg=0x02 with a PHY model driving 0 then 0x0141 → return_port=0x0141, error=0; mdio_oe=0 for the last 18 bits.
- Missing PHY: read with mdio_i floating at 1 → error=1 and return_port=0xFFFF at done_port.
- Ignored starts: start_port during RST_WAIT and during an active frame → no extra frame and no done_port.
- Reset mid-frame at bit 40 → eth_mdc=0, mdio_oe=0, eth_reset_n=0 next cycle; no done_port; the full reset sequence then repeats.
